// File: rtl/sdr_16_pkg.sv
// Shared definitions for the 16-bit SDR SDRAM controller: command pin
// encodings, Wishbone burst type encodings and mode register fields.
package sdr_16_pkg;

    // {ras_n, cas_n, we_n} as driven on the pins
    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_RFR = 3'b001,
        CMD_PCH = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_NOP = 3'b111
    } sdr_cmd_e;

    // Wishbone burst type extension
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    localparam int SDR_DW = 16;
    localparam int RD_DW  = 2 * SDR_DW;

    // Mode register fields
    localparam logic [2:0] LMR_CL2    = 3'd2;
    localparam logic [2:0] LMR_CL3    = 3'd3;
    localparam logic [2:0] LMR_BL2    = 3'b001;
    localparam logic       LMR_BT_SEQ = 1'b0;

    // Mode register word: {reserved, write burst mode, op mode, CL, BT, BL}
    function automatic logic [12:0] lmr_word(input logic [2:0] cl);
        return {3'b000, 1'b0, 2'b00, cl, LMR_BT_SEQ, LMR_BL2};
    endfunction

    // The init sequence programs this word; read capture derives its CAS
    // latency from the same field so the two cannot drift apart.
    localparam logic [12:0] INIT_LMR = lmr_word(LMR_CL2);
    localparam int          INIT_CL  = int'(INIT_LMR[6:4]);

endpackage

// File: rtl/sdr_16_rd_capture_if.sv
// Signal bundle between the command FSM / DQ pins / ingress FIFO and the
// read capture block.
//
// Handshake: a word on rd_dat_o transfers on every rising edge where
// rd_vld_o and rd_rdy_i are both high. rd_vld_o never depends on
// rd_rdy_i, and once raised it holds with stable data until taken.
interface sdr_16_rd_capture_if;
    import sdr_16_pkg::*;

    logic              cmd_read;
    logic [SDR_DW-1:0] dq_i;
    logic              dq_oe;
    logic [RD_DW-1:0]  rd_dat_o;
    logic              rd_vld_o;
    logic              rd_rdy_i;
    logic              rd_stall_o;
    logic              rd_ovf_o;
    logic              rd_busy_o;

    // Environment side: FSM strobes, pins and FIFO ready
    modport master (
        output cmd_read, dq_i, dq_oe, rd_rdy_i,
        input  rd_dat_o, rd_vld_o, rd_stall_o, rd_ovf_o, rd_busy_o
    );

    // Capture block side
    modport slave (
        input  cmd_read, dq_i, dq_oe, rd_rdy_i,
        output rd_dat_o, rd_vld_o, rd_stall_o, rd_ovf_o, rd_busy_o
    );

endinterface

// File: rtl/sdr_16_rd_buf.sv
// Circular FIFO with registered head. Pointers are one bit wider than the
// address so full and empty are distinguishable. head_vld/head_dat show the
// oldest entry after this edge's pop; a word pushed into an empty buffer
// appears one cycle after the push.
module sdr_16_rd_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_rst,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_vld,
    output logic [DW-1:0]            head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr, rptr_nxt;
    logic          wr_en, rd_en;

    assign count    = wptr - rptr;
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en    = pop & ~empty;
    // A pop in the same cycle frees the slot being written when full
    assign wr_en    = push & (~full | rd_en);
    assign rptr_nxt = rptr + {{AW{1'b0}}, rd_en};

    // Storage array, no reset needed: contents are qualified by the pointers
    always_ff @(posedge sdram_clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end

    // Pointer update
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            rptr <= rptr_nxt;
        end
    end

    // Registered head: reflects this edge's pop but not its push
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            head_vld <= (wptr != rptr_nxt);
            head_dat <= (wptr != rptr_nxt) ? mem[rptr_nxt[AW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/sdr_16_rd_capture.sv
// Read-data return path: tracks issued reads through a CAS-latency delay
// line, captures the two BL2 beats from the DQ pins, packs them into one
// 32-bit word and queues it for the ingress FIFO.
module sdr_16_rd_capture
    import sdr_16_pkg::*;
#(
    parameter int CL        = INIT_CL,
    parameter int RD_DLY    = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    sdr_16_rd_capture_if.slave  bus
);
    localparam int L  = CL + RD_DLY + 1;
    localparam int IW = $clog2(L + 1);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = IW + CW;
    localparam int B0 = CL + RD_DLY - 1;
    localparam int B1 = CL + RD_DLY;

    logic [SDR_DW-1:0] dq_q, hi_q;
    logic [L-1:0]      pend;
    logic [IW-1:0]     inflt;
    logic [CW-1:0]     count;
    logic [SW-1:0]     occ;
    logic [RD_DW-1:0]  word, head_dat;
    logic              beat0, beat1, pop, full, empty, drop, ovf_set;
    logic              head_vld, ovf_q, stall_q;

    assign beat0 = pend[B0];
    assign beat1 = pend[B1];
    assign word  = {hi_q, dq_q};
    assign pop   = head_vld & bus.rd_rdy_i;
    // Beat1 arriving at a full buffer with nothing leaving is lost
    assign drop  = beat1 & full & ~pop;
    // Back-to-back read strobes, a capture while we drive DQ, or a lost word
    assign ovf_set = (bus.cmd_read & pend[0]) | (bus.dq_oe & (beat0 | beat1)) | drop;
    assign occ     = SW'(count) + SW'(inflt);

    // DQ input register, free running
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) dq_q <= '0;
        else           dq_q <= bus.dq_i;
    end

    // Delay line marking where each read's beats will be on dq_q
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) pend <= '0;
        else           pend <= {pend[L-2:0], bus.cmd_read};
    end

    // Hold the first beat until the second one completes the word
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst)  hi_q <= '0;
        else if (beat0) hi_q <= dq_q;
    end

    // Reads issued but not yet pushed into the buffer
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            inflt <= '0;
        end else begin
            case ({bus.cmd_read, beat1})
                2'b10:   inflt <= inflt + IW'(1);
                2'b01:   inflt <= inflt - IW'(1);
                default: inflt <= inflt;
            endcase
        end
    end

    // Sticky error flag and registered stall hint
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            ovf_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            stall_q <= (occ >= SW'(BUF_DEPTH));
        end
    end

    sdr_16_rd_buf #(
        .DW    (RD_DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .push      (beat1),
        .wdata     (word),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_vld  (head_vld),
        .head_dat  (head_dat)
    );

    assign bus.rd_vld_o   = head_vld;
    assign bus.rd_dat_o   = head_dat;
    assign bus.rd_stall_o = stall_q;
    assign bus.rd_ovf_o   = ovf_q;
    assign bus.rd_busy_o  = (inflt != '0) | ~empty;

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Directed bench for the read capture path: one instance at default
// timing (CL=2, RD_DLY=1) and one at CL=3, sharing clock and reset.
module tb_sdr_16_rd_capture;
    import sdr_16_pkg::*;

    logic sdram_clk = 1'b0;
    logic sdram_rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    int acc3_cnt = 0;
    int vld_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp3_q[$];

    sdr_16_rd_capture_if bus ();
    sdr_16_rd_capture_if bus3 ();

    sdr_16_rd_capture dut (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .bus       (bus)
    );

    sdr_16_rd_capture #(.CL(3), .RD_DLY(1), .BUF_DEPTH(4)) dut3 (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .bus       (bus3)
    );

    // Clock
    always #5 sdram_clk = ~sdram_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard on both outputs, then advance to #1 after the next edge
    task automatic cycle();
        if (bus.rd_vld_o && bus.rd_rdy_i) begin
            if (exp_q.size() == 0) check("unexp_word", 32'(bus.rd_vld_o), 32'd0);
            else begin
                check("word", bus.rd_dat_o, exp_q.pop_front());
                acc_cnt++;
            end
        end
        if (bus3.rd_vld_o && bus3.rd_rdy_i) begin
            if (exp3_q.size() == 0) check("unexp_word3", 32'(bus3.rd_vld_o), 32'd0);
            else begin
                check("word3", bus3.rd_dat_o, exp3_q.pop_front());
                acc3_cnt++;
            end
        end
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic idle();
        bus.cmd_read  = 1'b0;
        bus.dq_i      = '0;
        bus.dq_oe     = 1'b0;
        bus.rd_rdy_i  = 1'b1;
        bus3.cmd_read = 1'b0;
        bus3.dq_i     = '0;
        bus3.dq_oe    = 1'b0;
        bus3.rd_rdy_i = 1'b1;
    endtask

    task automatic do_reset();
        sdram_rst = 1'b1;
        exp_q.delete();
        exp3_q.delete();
        acc_cnt  = 0;
        acc3_cnt = 0;
        repeat (2) cycle();
        sdram_rst = 1'b0;
        cycle();
    endtask

    initial begin
        idle();
        #1;
        // Reset state, checked while reset is held
        check("rst_vld",   32'(bus.rd_vld_o),   32'd0);
        check("rst_dat",   bus.rd_dat_o,        32'd0);
        check("rst_stall", 32'(bus.rd_stall_o), 32'd0);
        check("rst_ovf",   32'(bus.rd_ovf_o),   32'd0);
        check("rst_busy",  32'(bus.rd_busy_o),  32'd0);
        check("rst_vld3",  32'(bus3.rd_vld_o),  32'd0);
        do_reset();

        // Single read, defaults: cmd at E0, beats on pins at E0+2/E0+3
        bus.cmd_read = 1'b1; cycle();
        bus.cmd_read = 1'b0; cycle();
        bus.dq_i = 16'hABCD; cycle();
        bus.dq_i = 16'h1234; cycle();
        bus.dq_i = 16'h0000; cycle();
        check("single_vld_early", 32'(bus.rd_vld_o),  32'd0);
        check("single_busy",      32'(bus.rd_busy_o), 32'd1);
        exp_q.push_back(32'hABCD1234);
        cycle();
        check("single_vld", 32'(bus.rd_vld_o), 32'd1);
        check("single_dat", bus.rd_dat_o,      32'hABCD1234);
        cycle();
        check("single_vld_1cyc", 32'(bus.rd_vld_o),  32'd0);
        check("single_busy_end", 32'(bus.rd_busy_o), 32'd0);
        check("single_acc",      32'(acc_cnt),       32'd1);

        // Streaming at CL=3: 8 reads every 2 cycles, incrementing beats
        for (int k = 0; k < 8; k++)
            exp3_q.push_back({16'(32'h1000 + 2 * k), 16'(32'h1001 + 2 * k)});
        for (int n = 0; n < 30; n++) begin
            bus3.cmd_read = (n < 16) && (n % 2 == 0);
            bus3.dq_i     = (n >= 3) ? 16'(32'h1000 + n - 3) : 16'h0000;
            cycle();
        end
        check("stream_words", 32'(acc3_cnt),        32'd8);
        check("stream_ovf",   32'(bus3.rd_ovf_o),   32'd0);
        check("stream_busy",  32'(bus3.rd_busy_o),  32'd0);

        // Backpressure: 4 reads fill the buffer, a 5th is forced and dropped
        idle();
        do_reset();
        bus.rd_rdy_i = 1'b0;
        for (int n = 0; n < 20; n++) begin
            bus.cmd_read = ((n % 2 == 0) && (n < 8)) || (n == 12);
            bus.dq_i     = 16'(32'h2000 + n);
            cycle();
            if (n == 6)  check("bp_stall_pre",  32'(bus.rd_stall_o), 32'd0);
            if (n == 7)  check("bp_stall",      32'(bus.rd_stall_o), 32'd1);
            if (n == 11) begin
                check("bp_ovf_pre", 32'(bus.rd_ovf_o), 32'd0);
                check("bp_vld",     32'(bus.rd_vld_o), 32'd1);
                check("bp_head",    bus.rd_dat_o,      32'h20022003);
            end
            if (n == 17) check("bp_ovf_drop",   32'(bus.rd_ovf_o),   32'd1);
            if (n == 19) check("bp_stall_hold", 32'(bus.rd_stall_o), 32'd1);
        end
        for (int k = 0; k < 4; k++)
            exp_q.push_back({16'(32'h2002 + 2 * k), 16'(32'h2003 + 2 * k)});
        bus.cmd_read = 1'b0;
        bus.rd_rdy_i = 1'b1;
        repeat (8) cycle();
        check("bp_drain_cnt", 32'(acc_cnt),          32'd4);
        check("bp_drain_vld", 32'(bus.rd_vld_o),     32'd0);
        check("bp_busy_end",  32'(bus.rd_busy_o),    32'd0);
        check("bp_stall_end", 32'(bus.rd_stall_o),   32'd0);

        // Full buffer with push and pop on the same edge
        idle();
        do_reset();
        for (int k = 0; k < 5; k++)
            exp_q.push_back({16'(32'h3002 + 2 * k), 16'(32'h3003 + 2 * k)});
        for (int n = 0; n < 14; n++) begin
            bus.cmd_read = (n % 2 == 0) && (n <= 8);
            bus.dq_i     = 16'(32'h3000 + n);
            bus.rd_rdy_i = (n == 12);
            cycle();
        end
        check("fpp_ovf",  32'(bus.rd_ovf_o), 32'd0);
        check("fpp_acc",  32'(acc_cnt),      32'd1);
        check("fpp_head", bus.rd_dat_o,      32'h30043005);
        bus.rd_rdy_i = 1'b1;
        repeat (8) cycle();
        check("fpp_drain", 32'(acc_cnt),      32'd5);
        check("fpp_ovf_end", 32'(bus.rd_ovf_o), 32'd0);

        // Consecutive read strobes
        idle();
        do_reset();
        bus.rd_rdy_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            bus.cmd_read = (n < 2);
            cycle();
            if (n == 0) check("b2b_ovf_pre", 32'(bus.rd_ovf_o), 32'd0);
            if (n == 1) check("b2b_ovf",     32'(bus.rd_ovf_o), 32'd1);
        end
        idle();
        do_reset();
        check("ovf_cleared", 32'(bus.rd_ovf_o), 32'd0);

        // dq_oe during a capture strobe; the beat is still captured
        exp_q.push_back(32'h40024003);
        for (int n = 0; n < 10; n++) begin
            bus.cmd_read = (n == 0);
            bus.dq_oe    = (n == 1) || (n == 3);
            bus.dq_i     = 16'(32'h4000 + n);
            cycle();
            if (n == 1) check("oe_ovf_nostrobe", 32'(bus.rd_ovf_o), 32'd0);
            if (n == 3) check("oe_ovf_strobe",   32'(bus.rd_ovf_o), 32'd1);
        end
        check("oe_word_taken", 32'(acc_cnt), 32'd1);

        // Reset with 2 reads in flight and 2 words buffered
        idle();
        do_reset();
        bus.rd_rdy_i = 1'b0;
        for (int n = 0; n < 8; n++) begin
            bus.cmd_read = (n % 2 == 0);
            bus.dq_i     = 16'(32'h5000 + n);
            cycle();
        end
        check("mid_stall_pre", 32'(bus.rd_stall_o), 32'd1);
        check("mid_busy_pre",  32'(bus.rd_busy_o),  32'd1);
        idle();
        bus.rd_rdy_i = 1'b0;
        sdram_rst = 1'b1;
        #1;
        check("mid_rst_vld",   32'(bus.rd_vld_o),   32'd0);
        check("mid_rst_dat",   bus.rd_dat_o,        32'd0);
        check("mid_rst_stall", 32'(bus.rd_stall_o), 32'd0);
        check("mid_rst_ovf",   32'(bus.rd_ovf_o),   32'd0);
        check("mid_rst_busy",  32'(bus.rd_busy_o),  32'd0);
        repeat (2) cycle();
        sdram_rst = 1'b0;
        bus.rd_rdy_i = 1'b1;
        vld_seen = 0;
        for (int n = 0; n < 15; n++) begin
            cycle();
            if (bus.rd_vld_o) vld_seen++;
        end
        check("mid_no_stale", 32'(vld_seen),        32'd0);
        check("mid_acc",      32'(acc_cnt),         32'd0);
        check("mid_busy_end", 32'(bus.rd_busy_o),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
